softex_lane_xbar: RTL and testbench



---
 rtl/softex_pkg.sv | 20 ++
 rtl/softex_lane_fifo.sv | 96 +++++++++
 rtl/softex_lane_xbar.sv | 145 ++++++++++++++
 tb/tb_softex_lane_xbar.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/softex_pkg.sv
// softex_pkg: shared constants and types for the SoftEx datapath blocks.
//   LANE_DEPTH_DEF     default depth of each per-lane elastic FIFO
//   LANE_XBAR_MAX_LANES upper bound on lanes covered by the observation flags
//   lane_xbar_flags_t  per-FIFO empty/full vectors of the lane crossbar,
//                      reserved for observation by the controller
package softex_pkg;

    localparam int LANE_DEPTH_DEF      = 4;
    localparam int LANE_XBAR_MAX_LANES = 16;

    typedef struct packed {
        logic [LANE_XBAR_MAX_LANES-1:0] split_empty;
        logic [LANE_XBAR_MAX_LANES-1:0] split_full;
        logic [LANE_XBAR_MAX_LANES-1:0] merge_empty;
        logic [LANE_XBAR_MAX_LANES-1:0] merge_full;
        logic                           tag_empty;
        logic                           tag_full;
    } lane_xbar_flags_t;

endpackage

// File: rtl/softex_lane_fifo.sv
// softex_lane_fifo: registered synchronous FIFO, no fall-through.
//   clk_i, rst_i   clock and synchronous active-high reset
//   clear_i        synchronous flush, overrides push/pop in the same cycle
//   push_i/wdata_i write side; a push while full is ignored
//   pop_i/rdata_o  read side; rdata_o is the head entry, zero when empty
//   full_o/empty_o occupancy flags, derived from registered state only
module softex_lane_fifo
    import softex_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push_s, pop_s;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? {AW{1'b0}} : p + AW'(1);
    endfunction

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == {CW{1'b0}});
    assign push_s  = push_i & ~full_o;
    assign pop_s   = pop_i & ~empty_o;
    // Zero when empty keeps downstream data quiet after reset/flush.
    assign rdata_o = empty_o ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

    // Next-state for pointers, occupancy and storage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        mem_d    = mem_q;
        if (clear_i) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            cnt_d    = {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = wdata_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            cnt_q    <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is not reset: entries are only visible once pushed.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/softex_lane_xbar.sv
// softex_lane_xbar: splits wide beats element-wise across NUM_LANES
// decoupled lanes and re-merges the lane results in order.
//   clk_i, rst_i, clear_i        clock, sync reset, sync flush (same effect)
//   in_valid_i/in_ready_o        wide input handshake, in_data_i, in_strb_i
//   lane_valid_o/lane_ready_i    per-lane split side, lane_data_o
//   lane_valid_i/lane_ready_o    per-lane merge side, lane_data_i
//   out_valid_o/out_ready_i      wide output handshake, out_data_o, out_strb_o
//   in_cnt_o/out_cnt_o           accepted/emitted beat counters (wrap)
//   busy_o                       any internal FIFO holds data
module softex_lane_xbar
    import softex_pkg::*;
#(
    parameter int NUM_LANES     = 4,
    parameter int DATA_WIDTH    = 128,
    parameter int ELEMENT_WIDTH = 16,
    parameter int LANE_DEPTH    = LANE_DEPTH_DEF,
    parameter int TAG_DEPTH     = 2 * LANE_DEPTH + 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [DATA_WIDTH-1:0]   in_data_i,
    input  logic [DATA_WIDTH/8-1:0] in_strb_i,
    output logic [NUM_LANES-1:0]    lane_valid_o,
    input  logic [NUM_LANES-1:0]    lane_ready_i,
    output logic [DATA_WIDTH-1:0]   lane_data_o,
    input  logic [NUM_LANES-1:0]    lane_valid_i,
    output logic [NUM_LANES-1:0]    lane_ready_o,
    input  logic [DATA_WIDTH-1:0]   lane_data_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DATA_WIDTH-1:0]   out_data_o,
    output logic [DATA_WIDTH/8-1:0] out_strb_o,
    output logic [15:0]             in_cnt_o,
    output logic [15:0]             out_cnt_o,
    output logic                    busy_o
);

    localparam int LANE_W = DATA_WIDTH / NUM_LANES;
    localparam int N_EL   = DATA_WIDTH / ELEMENT_WIDTH;
    localparam int EPL    = N_EL / NUM_LANES;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int EW     = ELEMENT_WIDTH;

    logic [LANE_W-1:0]    split_wdata [NUM_LANES];
    logic [LANE_W-1:0]    split_rdata [NUM_LANES];
    logic [LANE_W-1:0]    merge_rdata [NUM_LANES];
    logic [NUM_LANES-1:0] split_full, split_empty;
    logic [NUM_LANES-1:0] merge_full, merge_empty;
    logic [NUM_LANES-1:0] split_pop, merge_push;
    logic                 tag_full, tag_empty;
    logic                 in_fire, out_fire;
    logic [15:0]          in_cnt_q, in_cnt_d;
    logic [15:0]          out_cnt_q, out_cnt_d;

    // Ready looks only at registered full flags, so there is no
    // combinational path from any consumer ready back to in_ready_o.
    assign in_ready_o   = ~(|split_full) & ~tag_full;
    assign in_fire      = in_valid_i & in_ready_o;
    assign lane_valid_o = ~split_empty;
    assign split_pop    = lane_valid_o & lane_ready_i;
    assign lane_ready_o = ~merge_full;
    assign merge_push   = lane_valid_i & lane_ready_o;
    assign out_valid_o  = ~(|merge_empty) & ~tag_empty;
    assign out_fire     = out_valid_o & out_ready_i;
    assign busy_o       = ~(&split_empty) | ~(&merge_empty) | ~tag_empty;
    assign in_cnt_o     = in_cnt_q;
    assign out_cnt_o    = out_cnt_q;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        // Element e travels on lane e % NUM_LANES in slot e / NUM_LANES;
        // the merge side applies the exact inverse.
        for (genvar s = 0; s < EPL; s++) begin : g_slot
            assign split_wdata[l][s*EW +: EW] = in_data_i[(s*NUM_LANES+l)*EW +: EW];
            assign out_data_o[(s*NUM_LANES+l)*EW +: EW] = merge_rdata[l][s*EW +: EW];
        end

        assign lane_data_o[l*LANE_W +: LANE_W] = split_rdata[l];

        softex_lane_fifo #(.WIDTH(LANE_W), .DEPTH(LANE_DEPTH)) u_split (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (clear_i),
            .push_i  (in_fire),
            .wdata_i (split_wdata[l]),
            .pop_i   (split_pop[l]),
            .rdata_o (split_rdata[l]),
            .full_o  (split_full[l]),
            .empty_o (split_empty[l])
        );

        softex_lane_fifo #(.WIDTH(LANE_W), .DEPTH(LANE_DEPTH)) u_merge (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .clear_i (clear_i),
            .push_i  (merge_push[l]),
            .wdata_i (lane_data_i[l*LANE_W +: LANE_W]),
            .pop_i   (out_fire),
            .rdata_o (merge_rdata[l]),
            .full_o  (merge_full[l]),
            .empty_o (merge_empty[l])
        );
    end

    // Strobes ride alongside the lanes; since every lane is strictly
    // FIFO, the tag head always belongs to the beat being merged.
    softex_lane_fifo #(.WIDTH(STRB_W), .DEPTH(TAG_DEPTH)) u_tag (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (in_fire),
        .wdata_i (in_strb_i),
        .pop_i   (out_fire),
        .rdata_o (out_strb_o),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    // Beat counters; flush wins over a same-cycle handshake.
    always_comb begin
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        if (clear_i) begin
            in_cnt_d  = 16'h0000;
            out_cnt_d = 16'h0000;
        end else begin
            in_cnt_d  = in_cnt_q + {15'h0000, in_fire};
            out_cnt_d = out_cnt_q + {15'h0000, out_fire};
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_cnt_q  <= 16'h0000;
            out_cnt_q <= 16'h0000;
        end else begin
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule

// File: tb/tb_softex_lane_xbar.sv
module tb_softex_lane_xbar;

    logic         clk_i = 1'b0;
    logic         rst_i, clear_i;
    logic         in_valid_i, in_ready_o;
    logic [127:0] in_data_i;
    logic [15:0]  in_strb_i;
    logic [3:0]   lane_valid_o, lane_ready_i, lane_valid_i, lane_ready_o;
    logic [127:0] lane_data_o, lane_data_i;
    logic         out_valid_o, out_ready_i;
    logic [127:0] out_data_o;
    logic [15:0]  out_strb_o, in_cnt_o, out_cnt_o;
    logic         busy_o;

    logic [3:0]   lane_en;
    logic         loop_mode;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  s;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Bench stands in for the lane array: either loops lanes back or just sinks them.
    assign lane_ready_i = loop_mode ? (lane_en & lane_ready_o) : lane_en;
    assign lane_valid_i = loop_mode ? (lane_en & lane_valid_o) : 4'h0;
    assign lane_data_i  = lane_data_o;

    softex_lane_xbar dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .in_strb_i(in_strb_i),
        .lane_valid_o(lane_valid_o), .lane_ready_i(lane_ready_i), .lane_data_o(lane_data_o),
        .lane_valid_i(lane_valid_i), .lane_ready_o(lane_ready_o), .lane_data_i(lane_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_strb_o(out_strb_o),
        .in_cnt_o(in_cnt_o), .out_cnt_o(out_cnt_o), .busy_o(busy_o)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Scoreboard: accepted inputs are expected unchanged at the output, in order.
    always @(negedge clk_i) begin
        if (!rst_i && !clear_i) begin
            if (in_valid_i && in_ready_o) exp_q.push_back({in_data_i, in_strb_i});
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    check_eq("out_unexpected", {127'd0, out_valid_o}, 128'd0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check_eq("out_data", out_data_o, e.d);
                    check_eq("out_strb", {112'd0, out_strb_o}, {112'd0, e.s});
                end
            end
        end
    end

    task automatic send_beat(input logic [127:0] d, input logic [15:0] s);
        int n = 0;
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_strb_i  = s;
        @(negedge clk_i);
        while (!in_ready_o && n < 200) begin
            n++;
            @(negedge clk_i);
        end
        if (!in_ready_o) check_eq("send_timeout", {127'd0, in_ready_o}, 128'd1);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            n++;
            @(negedge clk_i);
        end
        check_eq("drain", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        logic [127:0] d;
        int acc;
        int c0;
        rst_i = 1'b1; clear_i = 1'b0; in_valid_i = 1'b0; in_data_i = 128'd0;
        in_strb_i = 16'h0000; out_ready_i = 1'b1; lane_en = 4'hF; loop_mode = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Reset state
        @(negedge clk_i);
        check_eq("rst_in_ready", {127'd0, in_ready_o}, 128'd1);
        check_eq("rst_lane_valid", {124'd0, lane_valid_o}, 128'd0);
        check_eq("rst_lane_ready", {124'd0, lane_ready_o}, 128'hF);
        check_eq("rst_out_valid", {127'd0, out_valid_o}, 128'd0);
        check_eq("rst_out_data", out_data_o, 128'd0);
        check_eq("rst_out_strb", {112'd0, out_strb_o}, 128'd0);
        check_eq("rst_cnts", {96'd0, in_cnt_o, out_cnt_o}, 128'd0);
        check_eq("rst_busy", {127'd0, busy_o}, 128'd0);
        @(posedge clk_i); #1;

        // Mapping: element i holds value i
        d = 128'd0;
        for (int i = 0; i < 8; i++) d[i*16 +: 16] = 16'(i);
        send_beat(d, 16'hFFFF);
        @(negedge clk_i);
        check_eq("map_lane_valid", {124'd0, lane_valid_o}, 128'hF);
        check_eq("map_lane0", {96'd0, lane_data_o[31:0]},   128'h0004_0000);
        check_eq("map_lane1", {96'd0, lane_data_o[63:32]},  128'h0005_0001);
        check_eq("map_lane2", {96'd0, lane_data_o[95:64]},  128'h0006_0002);
        check_eq("map_lane3", {96'd0, lane_data_o[127:96]}, 128'h0007_0003);
        @(negedge clk_i);
        check_eq("map_latency", {127'd0, out_valid_o}, 128'd1);
        wait_drain();
        @(posedge clk_i); #1;

        // Strobe tagging with lane 2 delayed
        lane_en = 4'b1011;
        send_beat(rnd128(), 16'hFFFF);
        send_beat(rnd128(), 16'hFFFF);
        send_beat(rnd128(), 16'h00FF);
        for (int k = 0; k < 3; k++) begin
            repeat (5) begin
                @(negedge clk_i);
                check_eq("strb_hold", {127'd0, out_valid_o}, 128'd0);
            end
            @(posedge clk_i); #1 lane_en[2] = 1'b1;
            @(posedge clk_i); #1 lane_en[2] = 1'b0;
            @(negedge clk_i);
            check_eq("strb_deliver", {127'd0, out_valid_o}, 128'd1);
        end
        lane_en = 4'hF;
        wait_drain();
        @(posedge clk_i); #1;

        // Lane backpressure on lane 1
        lane_en = 4'b1101;
        acc = 0;
        in_valid_i = 1'b1;
        in_data_i = rnd128();
        in_strb_i = 16'h0F0F;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_i);
            if (in_ready_o) acc++;
            @(posedge clk_i); #1 in_data_i = rnd128();
        end
        in_valid_i = 1'b0;
        check_eq("bp_accepted", 128'(acc), 128'd4);
        @(negedge clk_i);
        check_eq("bp_stalled", {127'd0, in_ready_o}, 128'd0);
        @(posedge clk_i); #1 lane_en[1] = 1'b1;
        @(negedge clk_i);
        check_eq("bp_release_same", {127'd0, in_ready_o}, 128'd0);
        @(negedge clk_i);
        check_eq("bp_resume", {127'd0, in_ready_o}, 128'd1);
        wait_drain();
        @(posedge clk_i); #1;

        // Clear with 3 beats in flight
        lane_en = 4'h0;
        send_beat(rnd128(), 16'h1111);
        send_beat(rnd128(), 16'h2222);
        send_beat(rnd128(), 16'h3333);
        @(negedge clk_i);
        check_eq("clr_busy_before", {127'd0, busy_o}, 128'd1);
        @(posedge clk_i); #1;
        pulse_clear();
        @(negedge clk_i);
        check_eq("clr_busy", {127'd0, busy_o}, 128'd0);
        check_eq("clr_valids", {123'd0, lane_valid_o, out_valid_o}, 128'd0);
        check_eq("clr_cnts", {96'd0, in_cnt_o, out_cnt_o}, 128'd0);
        check_eq("clr_in_ready", {127'd0, in_ready_o}, 128'd1);
        @(posedge clk_i); #1;
        lane_en = 4'hF;
        send_beat(rnd128(), 16'hA5A5);
        wait_drain();
        check_eq("clr_fresh_out_cnt", {112'd0, out_cnt_o}, 128'd1);
        @(posedge clk_i); #1;
        pulse_clear();

        // Tag limit: lanes sink everything, merge side idle
        loop_mode = 1'b0;
        acc = 0;
        in_valid_i = 1'b1;
        in_data_i = rnd128();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            if (in_ready_o) acc++;
            @(posedge clk_i); #1 in_data_i = rnd128();
        end
        in_valid_i = 1'b0;
        @(negedge clk_i);
        check_eq("tag_accepted", 128'(acc), 128'd10);
        check_eq("tag_in_cnt", {112'd0, in_cnt_o}, 128'd10);
        check_eq("tag_out_cnt", {112'd0, out_cnt_o}, 128'd0);
        check_eq("tag_in_ready", {127'd0, in_ready_o}, 128'd0);
        check_eq("tag_lanes_drained", {124'd0, lane_valid_o}, 128'd0);
        @(posedge clk_i); #1;
        loop_mode = 1'b1;
        pulse_clear();

        // Throughput and counter wrap
        c0 = cyc;
        for (int i = 0; i < 65537; i++) send_beat(rnd128(), 16'($urandom()));
        check_eq("tput_cycles", 128'(cyc - c0), 128'd65537);
        wait_drain();
        @(negedge clk_i);
        check_eq("wrap_in_cnt", {112'd0, in_cnt_o}, 128'd1);
        check_eq("wrap_out_cnt", {112'd0, out_cnt_o}, 128'd1);
        check_eq("end_busy", {127'd0, busy_o}, 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
